// File: rtl/cond_unit.sv
// Conditional-execution stage: architectural NZCV register, condition check,
// write-strobe gating and saturating executed/squashed debug counters.
module cond_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end
endmodule

module cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             cnt_clr,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
);
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    nzcv_t                       flags_q;
    nzcv_t                       flags_d;
    logic                        go;
    logic [1:0]                  cnt_inc;
    logic [1:0][CNT_W-1:0]       cnt_q;

    // Condition is judged against the committed flags only, so a setter
    // sees the old values and its successor sees the new ones.
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            4'b0000: CondEx = flags_q.z;
            4'b0001: CondEx = ~flags_q.z;
            4'b0010: CondEx = flags_q.c;
            4'b0011: CondEx = ~flags_q.c;
            4'b0100: CondEx = flags_q.n;
            4'b0101: CondEx = ~flags_q.n;
            4'b0110: CondEx = flags_q.v;
            4'b0111: CondEx = ~flags_q.v;
            4'b1000: CondEx = flags_q.c & ~flags_q.z;
            4'b1001: CondEx = ~flags_q.c | flags_q.z;
            4'b1010: CondEx = (flags_q.n == flags_q.v);
            4'b1011: CondEx = (flags_q.n != flags_q.v);
            4'b1100: CondEx = ~flags_q.z & (flags_q.n == flags_q.v);
            4'b1101: CondEx = flags_q.z | (flags_q.n != flags_q.v);
            4'b1110: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

    assign go       = en & CondEx;
    assign PCSrc    = go & PCS;
    assign RegWrite = go & RegW & ~NoWrite;
    assign MemWrite = go & MemW;

    // N,Z and C,V halves commit independently; logic ops leave C,V alone.
    always_comb begin
        flags_d = flags_q;
        if (go && FlagW[1]) begin
            flags_d.n = ALUFlags[3];
            flags_d.z = ALUFlags[2];
        end
        if (go && FlagW[0]) begin
            flags_d.c = ALUFlags[1];
            flags_d.v = ALUFlags[0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            flags_q <= '0;
        else
            flags_q <= flags_d;
    end

    assign Flags = flags_q;

    assign cnt_inc[0] = en & CondEx;
    assign cnt_inc[1] = en & ~CondEx;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            cond_sat_cnt #(.W(CNT_W)) u_cnt (
                .clk     (clk),
                .reset_n (reset_n),
                .clr     (cnt_clr),
                .inc     (cnt_inc[gi]),
                .cnt     (cnt_q[gi])
            );
        end
    endgenerate

    assign exec_cnt   = cnt_q[0];
    assign squash_cnt = cnt_q[1];
endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: reference model feeds a scoreboard queue, a condition
// table drives the compare checks, hand sequences cover flags/counters/reset.
module tb_cond_unit;
    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic [3:0]    Cond;
    logic [3:0]    ALUFlags;
    logic [1:0]    FlagW;
    logic          PCS, RegW, MemW, NoWrite, cnt_clr;
    logic          PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0]    Flags;
    logic [CW-1:0] exec_cnt, squash_cnt;

    cond_unit #(.CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .cnt_clr(cnt_clr), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .CondEx(CondEx), .Flags(Flags), .exec_cnt(exec_cnt), .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          condex, pcsrc, regwr, memwr;
        logic [3:0]    flags;
        logic [CW-1:0] exec, squash;
    } exp_t;

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       exp;
    } cvec_t;

    exp_t          sb[$];
    cvec_t         tbl[16];
    int            total  = 0;
    int            passed = 0;
    logic [3:0]    m_flags;
    logic [CW-1:0] m_exec, m_squash;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference condition: base test from Cond[3:1], inverted by Cond[0].
    function automatic logic mcond(input logic [3:0] cd, input logic [3:0] f);
        logic fn, fz, fc, fv, r;
        {fn, fz, fc, fv} = f;
        case (cd[3:1])
            3'd0: r = fz;
            3'd1: r = fc;
            3'd2: r = fn;
            3'd3: r = fv;
            3'd4: r = fc & ~fz;
            3'd5: r = (fn == fv);
            3'd6: r = ~fz & (fn == fv);
            default: r = 1'b1;
        endcase
        if (cd == 4'hF) return 1'b0;
        return r ^ cd[0];
    endfunction

    // Called at posedge+1: drive, check strobes mid-cycle, check state after edge.
    task automatic step(input logic e, input logic [3:0] cd, input logic [1:0] fw,
                        input logic [3:0] alu, input logic pc, input logic rw,
                        input logic mw, input logic nw, input logic clr);
        exp_t x;
        logic p;
        en = e; Cond = cd; FlagW = fw; ALUFlags = alu;
        PCS = pc; RegW = rw; MemW = mw; NoWrite = nw; cnt_clr = clr;
        p = mcond(cd, m_flags);
        x.condex = p;
        x.pcsrc  = e & p & pc;
        x.regwr  = e & p & rw & ~nw;
        x.memwr  = e & p & mw;
        if (e && p) begin
            if (fw[1]) m_flags[3:2] = alu[3:2];
            if (fw[0]) m_flags[1:0] = alu[1:0];
        end
        if (clr) begin
            m_exec = '0; m_squash = '0;
        end else if (e) begin
            if (p && m_exec != CMAX) m_exec++;
            if (!p && m_squash != CMAX) m_squash++;
        end
        x.flags = m_flags; x.exec = m_exec; x.squash = m_squash;
        sb.push_back(x);
        #3;
        chk("CondEx",   CondEx,   sb[0].condex);
        chk("PCSrc",    PCSrc,    sb[0].pcsrc);
        chk("RegWrite", RegWrite, sb[0].regwr);
        chk("MemWrite", MemWrite, sb[0].memwr);
        @(posedge clk); #1;
        x = sb.pop_front();
        chk("Flags",      Flags,      x.flags);
        chk("exec_cnt",   exec_cnt,   x.exec);
        chk("squash_cnt", squash_cnt, x.squash);
    endtask

    task automatic setf(input logic [3:0] f);
        step(1, 4'hE, 2'b11, f, 0, 0, 0, 0, 0);
    endtask

    initial begin
        tbl[0]  = '{4'b1000, 4'b1010, 1'b0};  // GE
        tbl[1]  = '{4'b1000, 4'b1011, 1'b1};  // LT
        tbl[2]  = '{4'b1000, 4'b1100, 1'b0};  // GT
        tbl[3]  = '{4'b1000, 4'b1101, 1'b1};  // LE
        tbl[4]  = '{4'b1001, 4'b1010, 1'b1};
        tbl[5]  = '{4'b1001, 4'b1100, 1'b1};
        tbl[6]  = '{4'b0110, 4'b1000, 1'b0};  // HI
        tbl[7]  = '{4'b0110, 4'b1001, 1'b1};  // LS
        tbl[8]  = '{4'b0000, 4'b1111, 1'b0};  // reserved
        tbl[9]  = '{4'b0010, 4'b1000, 1'b1};
        tbl[10] = '{4'b0110, 4'b0000, 1'b1};
        tbl[11] = '{4'b0001, 4'b0110, 1'b1};
        tbl[12] = '{4'b0001, 4'b0111, 1'b0};
        tbl[13] = '{4'b1000, 4'b0100, 1'b1};
        tbl[14] = '{4'b0100, 4'b1100, 1'b0};
        tbl[15] = '{4'b1111, 4'b1111, 1'b0};

        reset_n = 1'b0; en = 0; Cond = 4'h0; ALUFlags = 0; FlagW = 0;
        PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; cnt_clr = 0;
        m_flags = '0; m_exec = '0; m_squash = '0;
        #1;
        chk("rst_flags",  Flags,      4'h0);
        chk("rst_exec",   exec_cnt,   4'h0);
        chk("rst_squash", squash_cnt, 4'h0);
        chk("rst_eq", CondEx, 1'b0);
        Cond = 4'h1; #1;
        chk("rst_ne", CondEx, 1'b1);
        @(posedge clk); #1;
        reset_n = 1'b1;

        step(1, 4'hE, 2'b00, 4'h0, 0, 1, 0, 0, 0);
        step(1, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0, 0);
        chk("squash_one", squash_cnt, 4'd1);

        // CMP equal, then BEQ store and BNE branch
        step(1, 4'hE, 2'b11, 4'b0110, 0, 1, 0, 1, 0);
        chk("cmp_flags", Flags, 4'b0110);
        step(1, 4'h0, 2'b00, 4'h0, 0, 0, 1, 0, 0);
        step(1, 4'h1, 2'b00, 4'h0, 1, 0, 0, 0, 0);

        step(1, 4'hE, 2'b10, 4'b1011, 0, 0, 0, 0, 0);
        chk("part_nz", Flags, 4'b1010);
        step(1, 4'hE, 2'b01, 4'b0001, 0, 0, 0, 0, 0);
        chk("part_cv", Flags, 4'b1001);

        setf(4'b0000);
        step(1, 4'h0, 2'b11, 4'b1111, 0, 1, 1, 0, 0);
        chk("fail_setter", Flags, 4'b0000);

        for (int i = 0; i < 16; i++) begin
            setf(tbl[i].flags);
            step(0, tbl[i].cond, 2'b11, ~tbl[i].flags, 1, 1, 1, 0, 0);
            chk($sformatf("cond_tbl%0d", i), CondEx, tbl[i].exp);
        end

        step(1, 4'hE, 2'b11, 4'b0100, 0, 0, 0, 0, 1);
        chk("clr_exec",   exec_cnt,   4'd0);
        chk("clr_squash", squash_cnt, 4'd0);
        chk("clr_flags",  Flags,      4'b0100);
        for (int i = 0; i < 20; i++) step(1, 4'hE, 2'b00, 4'h0, 0, 1, 0, 0, 0);
        chk("sat_exec", exec_cnt, 4'd15);
        for (int i = 0; i < 3; i++) step(0, 4'h1, 2'b11, 4'hF, 1, 1, 1, 0, 0);
        chk("bubble_exec",   exec_cnt,   4'd15);
        chk("bubble_squash", squash_cnt, 4'd0);
        chk("bubble_flags",  Flags,      4'b0100);

        // Asynchronous reset between edges with an update pending
        setf(4'b1111);
        en = 1; Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b0101;
        #2 reset_n = 1'b0;
        #1;
        chk("async_flags", Flags,    4'h0);
        chk("async_exec",  exec_cnt, 4'h0);
        @(posedge clk); #1;
        chk("held_flags", Flags, 4'h0);
        reset_n = 1'b1;
        m_flags = '0; m_exec = '0; m_squash = '0;
        step(1, 4'h0, 2'b00, 4'h0, 0, 1, 0, 0, 0);
        step(1, 4'h1, 2'b11, 4'b0100, 0, 1, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution stage that consumes the ALU's NZCV flags and sits between the ALU and the register-file, memory and PC write ports. It holds the architectural flags register and evaluates each instruction's 4-bit condition field against the stored flags. It gates the decoder's write strobes so that condition-failed instructions have no side effects. It also keeps saturating executed/squashed instruction counters for debug.

## Interface
- CNT_W, 16, width of each debug counter (≥2)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  instruction valid/advance this cycle; when 0 the cycle is a bubble
- Cond  in  4  instruction condition field [31:28]
- ALUFlags  in  4  {N,Z,C,V} from ALU for the current instruction
- FlagW  in  2  flag write request: [1] writes N,Z; [0] writes C,V
- PCS, RegW, MemW  in  1 each  decoder write requests
- NoWrite  in  1  suppresses register write (CMP/TST class)
- cnt_clr  in  1  synchronous clear of both counters
- PCSrc, RegWrite, MemWrite  out  1 each  gated strobes
- CondEx  out  1  condition passed for current Cond
- Flags  out  4  registered {N,Z,C,V}
- exec_cnt, squash_cnt  out  CNT_W each  debug counters

## Operation
- CondEx is combinational from Cond and the registered Flags (never ALUFlags):
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1
  - 1111 is reserved and evaluates to 0.
- Strobes:
  - PCSrc = en&CondEx&PCS
  - RegWrite = en&CondEx&RegW&~NoWrite
  - MemWrite = en&CondEx&MemW
- Flag update at the clock edge, only when en&CondEx:
  - FlagW[1] loads N,Z from ALUFlags[3:2].
  - FlagW[0] loads C,V from ALUFlags[1:0].
  - Unselected halves hold.
  - Logic ops must request FlagW=10: the ALU forces C,V to 0 for AND/ORR, and those values must not be committed.
- Counters, at the edge when en=1:
  - CondEx=1 increments exec_cnt; otherwise squash_cnt increments.
  - Each counter saturates at 2^CNT_W−1.
  - cnt_clr=1 zeroes both counters and overrides any increment in that cycle.
  - cnt_clr does not affect Flags.
- en=0: no flag update, no counter change, all strobes 0.

## Timing
- Reset (reset_n=0) clears Flags=0000, exec_cnt=0, squash_cnt=0 immediately, regardless of clk.
- Strobes and CondEx are combinational functions of the reset-state flags. Out of reset with Cond=EQ, CondEx=0; with Cond=NE, CondEx=1.
- Strobe latency is 0 cycles (same cycle as the inputs). Flag write latency is 1 cycle: new flags are visible on Flags and used by CondEx from the next cycle.
- A flag-setting instruction evaluates its own Cond against the old flags. Back-to-back CMP then BEQ resolves correctly on the second cycle.
- A condition-failed instruction with FlagW≠00 leaves Flags unchanged.
- Reset asserted mid-sequence discards any pending update. On release, the first edge behaves as after power-up.
- Inputs must be stable before the rising edge. There is no internal pipelining beyond the flag and counter registers.

## Test plan
- Reset, then Cond=1110 RegW=1 en=1 → RegWrite=1, CondEx=1. Cond=0000 → CondEx=0, squash_cnt=1 after the edge.
- CMP-equal: Cond=1110 FlagW=11 RegW=1 NoWrite=1 ALUFlags=0110 → RegWrite=0. Next cycle Flags=0110. Then Cond=0000 MemW=1 → MemWrite=1; Cond=0001 PCS=1 → PCSrc=0.
- Partial write: Flags=0110, FlagW=10, ALUFlags=1011 → Flags=1010. Then FlagW=01, ALUFlags=0001 → Flags=1001.
- Failed setter: Flags=0000, Cond=0000 FlagW=11 ALUFlags=1111 → Flags stay 0000, squash_cnt increments.
- Signed compares:
  - Flags=1000: GE=0, LT=1, GT=0, LE=1.
  - Flags=1001: GE=1, GT=1.
  - Flags=0110: HI=0, LS=1.
  - Cond=1111 → CondEx=0.
- CNT_W=4: 20 executed instructions → exec_cnt=15. en=0 cycles → no change. cnt_clr together with en=1 → both 0. Async reset_n pulse between edges → Flags=0000 at once.
